// File: rtl/apb_master.sv
// APB master: accepts one host request at a time and runs it as an APB
// SETUP/ACCESS transfer, returning a single-cycle completion pulse.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  preset,
  // host request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [3:0]            req_stb,
  // host response
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  // APB
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write;
    logic [3:0]            stb;
  } apb_req_t;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } apb_resp_t;

  state_t    state, state_nxt;
  apb_req_t  req_q;
  apb_resp_t resp_q;
  logic [CW-1:0] wait_cnt;
  logic accept, xfer_done, xfer_tmo;

  // Handshake and APB control are pure decodes of the state register.
  assign req_ready = (state == IDLE);
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

  assign accept    = req_ready & req_valid;
  assign xfer_done = (state == ACCESS) & pready;
  assign xfer_tmo  = (TIMEOUT != 0) && (state == ACCESS) && !pready &&
                     (wait_cnt == CW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done || xfer_tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request fields stay frozen from accept until the next accept, so the bus
  // is stable across the whole transfer and parked on the last value in IDLE.
  always_ff @(posedge pclk) begin
    if (preset) begin
      req_q    <= '0;
      resp_q   <= '0;
      wait_cnt <= '0;
    end else begin
      resp_q.valid <= xfer_done | xfer_tmo;
      resp_q.err   <= xfer_tmo | (xfer_done & perr);
      resp_q.rdata <= (xfer_done && !req_q.write && !perr) ? prdata : '0;
      if (accept) begin
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        req_q.write <= req_write;
        req_q.stb   <= req_stb;
        wait_cnt    <= '0;
      end else if (state == ACCESS && !pready && wait_cnt != {CW{1'b1}}) begin
        // saturate rather than wrap so a disabled timeout never aliases
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  assign paddr      = req_q.addr;
  assign pdata      = req_q.wdata;
  assign pwrite     = req_q.write;
  assign pstb       = req_q.stb;
  assign resp_valid = resp_q.valid;
  assign resp_err   = resp_q.err;
  assign resp_rdata = resp_q.rdata;

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master: a responder model plays back a
// per-transfer wait/error plan, and a monitor matches each completion pulse.
module tb_apb_master;
  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_stb = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] paddr, pdata, prdata = '0;
  logic        psel, penable, pwrite;
  logic [3:0]  pstb;
  logic        pready = 1'b0, perr = 1'b0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_stb(req_stb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  stb;
    int          w;       // pready-low ACCESS cycles the responder inserts
    logic        perr;
    logic [31:0] prdata;
  } plan_t;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Completion = 3 cycles + waits after accept; a responder slower than TO
  // waits is cut off after exactly TO waits with an error and no data.
  function automatic exp_t model(input plan_t p, input int unsigned acc_cyc);
    exp_t e;
    if (p.w > TO) begin
      e.err = 1'b1; e.rdata = '0; e.cyc = acc_cyc + 2 + TO;
    end else begin
      e.err   = p.perr;
      e.rdata = (!p.write && !p.perr) ? p.prdata : 32'h0;
      e.cyc   = acc_cyc + 2 + p.w;
    end
    return e;
  endfunction

  // Present a request; while not ready, scramble fields to show they are ignored.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input logic [3:0] s, input int w, input logic pe,
                       input logic [31:0] rd);
    plan_t p;
    int n = 0;
    bit done = 0;
    p.addr = a; p.wdata = d; p.write = wr; p.stb = s; p.w = w; p.perr = pe; p.prdata = rd;
    while (!done) begin
      @(negedge pclk);
      req_valid = 1'b1;
      if (req_ready) begin
        req_addr = a; req_wdata = d; req_write = wr; req_stb = s;
        plan_q.push_back(p);
        exp_q.push_back(model(p, cyc + 1));
        done = 1;
      end else begin
        req_addr = $urandom; req_wdata = $urandom;
        req_write = 1'($urandom); req_stb = 4'($urandom);
        n++;
        if (n > 40) begin
          errors++; checks++;
          $display("FAIL req_ready_wait: got 0 expected 1 within 40 cycles");
          done = 1;
        end
      end
    end
    @(posedge pclk);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge pclk);
      req_valid = 1'b0;
    end
  endtask

  // Responder: plays the plan for each transfer and checks bus stability.
  plan_t cur;
  int acnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  always @(negedge pclk) begin
    if (preset) begin
      pready = 1'b0; perr = 1'b0; last_addr = '0; last_wdata = '0;
    end else if (psel && !penable) begin
      if (plan_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL setup_unplanned: got psel=1 expected no transfer");
      end else begin
        cur = plan_q.pop_front();
        acnt = 0;
        last_addr = cur.addr; last_wdata = cur.wdata;
        chk("setup_paddr", paddr, cur.addr);
        chk("setup_pdata", pdata, cur.wdata);
        chk("setup_pctl", {pwrite, pstb}, {cur.write, cur.stb});
      end
      pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
    end else if (psel && penable) begin
      chk("access_paddr", paddr, cur.addr);
      chk("access_pdata", pdata, cur.wdata);
      chk("access_pctl", {pwrite, pstb}, {cur.write, cur.stb});
      if (acnt >= cur.w) begin
        pready = 1'b1; perr = cur.perr; prdata = cur.prdata;
      end else begin
        pready = 1'b0; perr = 1'($urandom); prdata = $urandom;
      end
      acnt++;
    end else begin
      chk("idle_penable", penable, 1'b0);
      chk("idle_ready", req_ready, 1'b1);
      chk("idle_paddr", paddr, last_addr);
      chk("idle_pdata", pdata, last_wdata);
      pready = 1'($urandom); perr = 1'($urandom); prdata = $urandom;
    end
  end

  // Monitor: every completion pulse must match the oldest outstanding request.
  always @(negedge pclk) begin
    if (!preset && resp_valid) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL resp_unexpected: got resp_valid=1 expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_pstb", pstb, 4'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pdata", pdata, 32'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    preset = 1'b0;

    // directed: zero-wait write, waited read on the timeout boundary, error
    // read, timeout and recovery, one-past-boundary timeout
    issue(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 0, 1'b0, 32'h0);
    gap(2);
    issue(32'h20, 32'h0, 1'b0, 4'h0, 4, 1'b0, 32'h12345678);
    issue(32'h30, 32'h55AA55AA, 1'b0, 4'h3, 0, 1'b1, 32'hCAFEF00D);
    issue(32'h40, 32'h0, 1'b0, 4'h1, 20, 1'b0, 32'hFFFFFFFF);
    issue(32'h44, 32'hA5A5A5A5, 1'b1, 4'hC, 0, 1'b0, 32'h0);
    issue(32'h48, 32'h0, 1'b0, 4'h2, TO + 1, 1'b0, 32'h13572468);

    // reset in the middle of ACCESS: transfer dropped without a response
    issue(32'h50, 32'h11112222, 1'b1, 4'hF, 3, 1'b0, 32'h0);
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    chk("abort_in_access", penable, 1'b1);
    preset = 1'b1;
    @(negedge pclk);
    exp_q.delete();
    plan_q.delete();
    chk("abort_psel", psel, 1'b0);
    chk("abort_penable", penable, 1'b0);
    chk("abort_resp_valid", resp_valid, 1'b0);
    preset = 1'b0;
    @(negedge pclk);
    chk("abort_ready", req_ready, 1'b1);
    repeat (4) @(negedge pclk);
    chk("abort_no_resp", resp_valid, 1'b0);

    // random traffic, including back-to-back requests
    repeat (80) begin
      issue($urandom, $urandom, 1'($urandom), 4'($urandom),
            $urandom_range(0, TO + 2), 1'($urandom_range(0, 3) == 0), $urandom);
      gap($urandom_range(0, 2));
    end

    begin
      int n = 0;
      gap(1);
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge pclk);
        n++;
      end
      chk("drain_exp", 64'(exp_q.size()), 64'd0);
      chk("drain_plan", 64'(plan_q.size()), 64'd0);
    end
    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 Parameter DATA_WIDTH, default 32, data bus width.
REQ-003 Parameter TIMEOUT, default 255, max ACCESS wait cycles; 0 disables timeout.
REQ-004 pclk  in  1  sole clock, all logic rising-edge.
REQ-005 preset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  master can accept request this cycle.
REQ-008 req_addr  in  ADDR_WIDTH  transfer address.
REQ-009 req_wdata  in  DATA_WIDTH  write data.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_stb  in  4  byte strobes for writes.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid.
REQ-014 resp_err  out  1  error flag, valid with resp_valid.
REQ-015 paddr  out  ADDR_WIDTH  APB address.
REQ-016 pdata  out  DATA_WIDTH  APB write data.
REQ-017 prdata  in  DATA_WIDTH  APB read data from responder.
REQ-018 psel, penable, pwrite  out  1 each  APB select, enable, direction.
REQ-019 pstb  out  4  APB byte strobes.
REQ-020 pready, perr  in  1 each  responder ready and error.

Function
REQ-021 FSM states IDLE, SETUP, ACCESS shall be encoded in registers; all outputs shall be registered or decoded from state.
REQ-022 req_ready shall be 1 exactly when state = IDLE.
REQ-023 On req_valid & req_ready at an edge, the master shall latch addr/wdata/write/stb into paddr/pdata/pwrite/pstb and enter SETUP.
REQ-024 SETUP: psel=1, penable=0; the next edge unconditionally enters ACCESS.
REQ-025 ACCESS: psel=1, penable=1; paddr/pdata/pwrite/pstb held stable from SETUP through the end of ACCESS.
REQ-026 ACCESS with pready=1 at an edge: enter IDLE; the next cycle shall have resp_valid=1, resp_err=perr, and resp_rdata=prdata for a read with perr=0, else 0.
REQ-027 ACCESS with pready=0: remain in ACCESS; the wait counter shall increment once per such edge.
REQ-028 If TIMEOUT!=0 and the wait counter equals TIMEOUT with pready=0: enter IDLE; the next cycle shall have resp_valid=1, resp_err=1, resp_rdata=0.
REQ-029 The wait counter shall be ceil(log2(TIMEOUT+1)) bits, min 1 bit; it shall clear on entry to SETUP and never wrap.
REQ-030 In IDLE, psel=0 and penable=0; paddr/pdata/pwrite/pstb shall hold their last values.
REQ-031 resp_valid shall be exactly one cycle per accepted request; there is no backpressure on the response.
REQ-032 A new request shall be accepted in the same cycle resp_valid=1 (back-to-back throughput one transfer per 3 cycles at zero wait).
REQ-033 Latency from the accept edge to resp_valid high shall be 3 cycles plus the number of wait cycles.
REQ-034 req_valid while req_ready=0 shall be ignored and not queued.
REQ-035 pstb shall be driven as latched for reads too; the responder shall ignore it.

Reset
REQ-036 preset=1 at an edge shall force state=IDLE, psel=0, penable=0, pwrite=0, pstb=0, paddr=0, pdata=0, resp_valid=0, resp_err=0, resp_rdata=0, wait counter=0.
REQ-037 Reset during SETUP or ACCESS shall abort the transfer with no resp_valid; req_ready=1 in the first cycle after reset releases.

Verification
REQ-038 Zero-wait write addr=0x10, wdata=0xDEADBEEF, stb=0xF -> SETUP then ACCESS, psel 2 cycles, penable 1 cycle; resp_valid 3 cycles after accept with err=0, rdata=0.
REQ-039 Read addr=0x20 with pready low 4 cycles, prdata=0x12345678 -> penable high 5 cycles; resp_valid at latency 7 with rdata=0x12345678.
REQ-040 Read with pready=1, perr=1 -> resp_err=1, resp_rdata=0.
REQ-041 TIMEOUT=3, pready held 0 -> after 3 waits psel drops; resp_valid=1, resp_err=1; next request accepted.
REQ-042 Two back-to-back requests held valid -> second accepted in the cycle of the first resp_valid; paddr changes only in IDLE/accept.
REQ-043 preset asserted during ACCESS -> psel=penable=0 next cycle, no resp_valid, req_ready=1 after release.
